// File: rtl/shift_pkg.sv
// ============================================================================
// Module      : shift_pkg
// Description : Shared types and sizing helpers for the PISO serializer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package shift_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    localparam int WORD_CNT_W = 8;
    localparam int GAP_CNT_W  = 4;

    // Bit counter width; never narrower than one bit.
    function automatic int bit_cnt_w(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/piso_shift_core.sv
// ============================================================================
// Module      : piso_shift_core
// Description : Loadable shift register with selectable output end.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module piso_shift_core #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_shift_en,
    input  logic [WIDTH-1:0] i_din,
    output logic             o_bit
);

    logic [WIDTH-1:0] r_sreg;
    logic [WIDTH-1:0] w_shifted;

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_shifted = {r_sreg[WIDTH-2:0], 1'b0};
            assign o_bit     = r_sreg[WIDTH-1];
        end else begin : g_lsb_first
            assign w_shifted = {1'b0, r_sreg[WIDTH-1:1]};
            assign o_bit     = r_sreg[0];
        end
    endgenerate

    // Load wins over shift so a back-to-back word replaces the spent one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sreg <= '0;
        end else if (i_load) begin
            r_sreg <= i_din;
        end else if (i_shift_en) begin
            r_sreg <= w_shifted;
        end
    end

endmodule

`default_nettype wire

// File: rtl/piso_serializer.sv
// ============================================================================
// Module      : piso_serializer
// Description : Valid/ready parallel-in serial-out stage with framing marks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module piso_serializer
    import shift_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1,
    parameter int GAP       = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      din,
    input  logic                  din_valid,
    output logic                  din_ready,
    output logic                  so,
    output logic                  so_valid,
    output logic                  sof,
    output logic                  busy,
    output logic [WORD_CNT_W-1:0] word_cnt
);

    localparam int c_BIT_CNT_W = bit_cnt_w(WIDTH);
    localparam logic [c_BIT_CNT_W-1:0] c_BIT_LAST = c_BIT_CNT_W'(WIDTH - 1);
    localparam logic [GAP_CNT_W-1:0]   c_GAP_LAST = GAP_CNT_W'((GAP > 0) ? GAP - 1 : 0);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [c_BIT_CNT_W-1:0]  r_bit_cnt;
    logic [c_BIT_CNT_W-1:0]  w_bit_cnt_nxt;
    logic [GAP_CNT_W-1:0]    r_gap_cnt;
    logic [GAP_CNT_W-1:0]    w_gap_cnt_nxt;
    logic [WORD_CNT_W-1:0]   r_word_cnt;
    logic                    w_ready;
    logic                    w_load;
    logic                    w_shift_en;
    logic                    w_last_bit;
    logic                    w_core_bit;

    piso_shift_core #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_core (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_shift_en (w_shift_en),
        .i_din      (din),
        .o_bit      (w_core_bit)
    );

    assign w_last_bit = (r_bit_cnt == c_BIT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_bit_cnt  <= '0;
            r_gap_cnt  <= '0;
            r_word_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_gap_cnt <= w_gap_cnt_nxt;
            if (w_load) begin
                r_word_cnt <= r_word_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_gap_cnt_nxt = r_gap_cnt;
        w_ready       = 1'b0;
        w_load        = 1'b0;
        w_shift_en    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (din_valid) begin
                    w_load        = 1'b1;
                    w_state_nxt   = S_SHIFT;
                    w_bit_cnt_nxt = '0;
                end
            end
            S_SHIFT: begin
                if (w_last_bit) begin
                    w_bit_cnt_nxt = '0;
                    if (GAP == 0) begin
                        // Ready on the last bit lets a new word follow with no bubble.
                        w_ready = 1'b1;
                        if (din_valid) begin
                            w_load = 1'b1;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_state_nxt   = S_GAP;
                        w_gap_cnt_nxt = '0;
                    end
                end else begin
                    w_shift_en    = 1'b1;
                    w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                end
            end
            S_GAP: begin
                if (r_gap_cnt == c_GAP_LAST) begin
                    w_state_nxt   = S_IDLE;
                    w_gap_cnt_nxt = '0;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // All outputs derive from flops only; din never reaches so directly.
    assign din_ready = w_ready;
    assign so_valid  = (r_state == S_SHIFT);
    assign so        = so_valid & w_core_bit;
    assign sof       = so_valid & (r_bit_cnt == '0);
    assign busy      = (r_state != S_IDLE);
    assign word_cnt  = r_word_cnt;

endmodule

`default_nettype wire

// File: tb/tb_piso_serializer.sv
// ============================================================================
// Module      : tb_piso_serializer
// Description : Directed table-driven bench for three serializer configurations.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_piso_serializer;

    typedef struct {
        int         unit;
        logic       dv;
        logic [3:0] din;
        logic       so;
        logic       sv;
        logic       sof;
        logic       busy;
        logic       rdy;
    } row_t;

    row_t       rows[$];
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] din;
    logic [2:0] dv;
    logic [2:0] rdy, so, sv, sof, busy;
    logic [7:0] wc0, wc1, wc2;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    // unit 0: MSB first, no gap; unit 1: LSB first; unit 2: MSB first, GAP=2
    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .GAP(0)) u_dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(dv[0]), .din_ready(rdy[0]),
        .so(so[0]), .so_valid(sv[0]), .sof(sof[0]), .busy(busy[0]), .word_cnt(wc0));
    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0), .GAP(0)) u_lsb (
        .clk(clk), .rst(rst), .din(din), .din_valid(dv[1]), .din_ready(rdy[1]),
        .so(so[1]), .so_valid(sv[1]), .sof(sof[1]), .busy(busy[1]), .word_cnt(wc1));
    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .GAP(2)) u_gap (
        .clk(clk), .rst(rst), .din(din), .din_valid(dv[2]), .din_ready(rdy[2]),
        .so(so[2]), .so_valid(sv[2]), .sof(sof[2]), .busy(busy[2]), .word_cnt(wc2));

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input int u, input logic d, input logic [3:0] w,
                                input logic e_so, input logic e_sv, input logic e_sof,
                                input logic e_busy, input logic e_rdy);
        rows.push_back('{unit:u, dv:d, din:w, so:e_so, sv:e_sv, sof:e_sof,
                         busy:e_busy, rdy:e_rdy});
    endfunction

    // Each row: inputs presented this cycle, outputs expected this cycle.
    task automatic run_rows(input string tag);
        foreach (rows[i]) begin
            int u;
            u     = rows[i].unit;
            din   = rows[i].din;
            dv    = '0;
            dv[u] = rows[i].dv;
            check($sformatf("%s[%0d].so",   tag, i), 8'(so[u]),   8'(rows[i].so));
            check($sformatf("%s[%0d].sv",   tag, i), 8'(sv[u]),   8'(rows[i].sv));
            check($sformatf("%s[%0d].sof",  tag, i), 8'(sof[u]),  8'(rows[i].sof));
            check($sformatf("%s[%0d].busy", tag, i), 8'(busy[u]), 8'(rows[i].busy));
            check($sformatf("%s[%0d].rdy",  tag, i), 8'(rdy[u]),  8'(rows[i].rdy));
            tick();
        end
        rows.delete();
        dv = '0;
    endtask

    initial begin
        din = 4'h0;
        dv  = '0;
        rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        check("rst.so",   8'(so),   8'h0);
        check("rst.sv",   8'(sv),   8'h0);
        check("rst.sof",  8'(sof),  8'h0);
        check("rst.busy", 8'(busy), 8'h0);
        check("rst.wc0",  wc0,      8'h0);
        @(negedge clk) rst = 1'b1;
        tick();
        check("rst.rdy",  8'(rdy),  8'h7);

        // Single word 1011, MSB first
        add(0, 1, 4'hB, 0, 0, 0, 0, 1);
        add(0, 0, 4'hB, 1, 1, 1, 1, 0);
        add(0, 0, 4'hB, 0, 1, 0, 1, 0);
        add(0, 0, 4'hB, 1, 1, 0, 1, 0);
        add(0, 0, 4'hB, 1, 1, 0, 1, 1);
        add(0, 0, 4'hB, 0, 0, 0, 0, 1);
        run_rows("single");
        check("single.wc", wc0, 8'd1);

        // Back-to-back A then 5 with valid held
        add(0, 1, 4'hA, 0, 0, 0, 0, 1);
        add(0, 1, 4'h5, 1, 1, 1, 1, 0);
        add(0, 1, 4'h5, 0, 1, 0, 1, 0);
        add(0, 1, 4'h5, 1, 1, 0, 1, 0);
        add(0, 1, 4'h5, 0, 1, 0, 1, 1);
        add(0, 0, 4'h5, 0, 1, 1, 1, 0);
        add(0, 0, 4'h5, 1, 1, 0, 1, 0);
        add(0, 0, 4'h5, 0, 1, 0, 1, 0);
        add(0, 0, 4'h5, 1, 1, 0, 1, 1);
        add(0, 0, 4'h5, 0, 0, 0, 0, 1);
        run_rows("b2b");
        check("b2b.wc", wc0, 8'd3);

        // LSB first, 1011 -> 1,1,0,1
        add(1, 1, 4'hB, 0, 0, 0, 0, 1);
        add(1, 0, 4'hB, 1, 1, 1, 1, 0);
        add(1, 0, 4'hB, 1, 1, 0, 1, 0);
        add(1, 0, 4'hB, 0, 1, 0, 1, 0);
        add(1, 0, 4'hB, 1, 1, 0, 1, 1);
        add(1, 0, 4'hB, 0, 0, 0, 0, 1);
        run_rows("lsb");
        check("lsb.wc", wc1, 8'd1);

        // GAP=2: F then 1; two gap cycles, one idle accept cycle
        add(2, 1, 4'hF, 0, 0, 0, 0, 1);
        add(2, 1, 4'h1, 1, 1, 1, 1, 0);
        add(2, 1, 4'h1, 1, 1, 0, 1, 0);
        add(2, 1, 4'h1, 1, 1, 0, 1, 0);
        add(2, 1, 4'h1, 1, 1, 0, 1, 0);
        add(2, 1, 4'h1, 0, 0, 0, 1, 0);
        add(2, 1, 4'h1, 0, 0, 0, 1, 0);
        add(2, 1, 4'h1, 0, 0, 0, 0, 1);
        add(2, 0, 4'h1, 0, 1, 1, 1, 0);
        add(2, 0, 4'h1, 0, 1, 0, 1, 0);
        add(2, 0, 4'h1, 0, 1, 0, 1, 0);
        add(2, 0, 4'h1, 1, 1, 0, 1, 0);
        add(2, 0, 4'h1, 0, 0, 0, 1, 0);
        add(2, 0, 4'h1, 0, 0, 0, 1, 0);
        add(2, 0, 4'h1, 0, 0, 0, 0, 1);
        run_rows("gap");
        check("gap.wc", wc2, 8'd2);

        // Mid-word asynchronous reset with din_valid held
        din   = 4'hC;
        dv[0] = 1'b1;
        tick();
        check("mid.b0.so",  8'(so[0]),  8'h1);
        check("mid.b0.sof", 8'(sof[0]), 8'h1);
        tick();
        check("mid.b1.so",  8'(so[0]),  8'h1);
        tick();
        check("mid.b2.sv",  8'(sv[0]),  8'h1);
        rst = 1'b0;
        #1;
        check("mid.so",   8'(so),   8'h0);
        check("mid.sv",   8'(sv),   8'h0);
        check("mid.sof",  8'(sof),  8'h0);
        check("mid.busy", 8'(busy), 8'h0);
        check("mid.wc0",  wc0,      8'h0);
        check("mid.wc2",  wc2,      8'h0);
        tick();
        tick();
        check("mid.hold.busy", 8'(busy[0]), 8'h0);
        dv = '0;
        @(negedge clk) rst = 1'b1;
        tick();
        check("mid.rel.rdy", 8'(rdy[0]), 8'h1);
        add(0, 1, 4'h3, 0, 0, 0, 0, 1);
        add(0, 0, 4'h3, 0, 1, 1, 1, 0);
        add(0, 0, 4'h3, 0, 1, 0, 1, 0);
        add(0, 0, 4'h3, 1, 1, 0, 1, 0);
        add(0, 0, 4'h3, 1, 1, 0, 1, 1);
        add(0, 0, 4'h3, 0, 0, 0, 0, 1);
        run_rows("after");
        check("after.wc", wc0, 8'd1);

        // Counter wrap: accepts every 4 edges with valid held
        rst = 1'b0;
        #1 rst = 1'b1;
        din   = 4'h6;
        dv[0] = 1'b1;
        repeat (1017) tick();
        check("wrap.255", wc0, 8'd255);
        repeat (4) tick();
        check("wrap.0", wc0, 8'd0);
        dv = '0;
        repeat (5) tick();
        check("wrap.idle.busy", 8'(busy[0]), 8'h0);
        check("wrap.idle.rdy",  8'(rdy[0]),  8'h1);
        check("wrap.hold", wc0, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
